// File: rtl/combin_seq_pkg.sv
// Shared types for the combin line sequencer: FSM state encoding and the
// state constants used by the datapath to spot line boundaries.
package combin_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_CMD   = 3'd2,
    ST_LINE  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  localparam seq_state_t ALIGN_STATE = ST_ALIGN;
  localparam seq_state_t FLUSH_STATE = ST_FLUSH;

endpackage

// File: rtl/combin_seq_addr_gen.sv
// Line address accumulator: base + line*stride built by repeated addition,
// plus the line index of the frame in progress.
module combin_seq_addr_gen #(
  parameter int ASIZE = 32,
  parameter int LSIZE = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [ASIZE-1:0] base,
  input  logic [ASIZE-1:0] stride,
  input  logic             advance,
  output logic [ASIZE-1:0] addr,
  output logic [LSIZE-1:0] line
);

  logic [ASIZE-1:0] stride_q;

  // Capture base/stride on frame start, step one stride per finished line.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      stride_q <= '0;
      line     <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
      line     <= '0;
    end else if (advance) begin
      addr     <= addr + stride_q;
      line     <= line + LSIZE'(1);
    end
  end

endmodule

// File: rtl/combin_line_sequencer.sv
// Frame/line controller feeding the combin_data packer in LINE mode.
// Optional feature macro: COMBIN_SEQ_LEN_CHECK_EN builds the packed-word
// counter and the sticky err_len check; without it err_len is tied low.
//
// state | meaning
// IDLE  | waiting for start
// ALIGN | one-cycle packer align pulse, counters cleared
// CMD   | line write command offered until accepted
// LINE  | accepting hactive pixels into the packer
// FLUSH | waiting for the packer's last-word strobe
// DONE  | one-cycle frame_done
module combin_line_sequencer
  import combin_seq_pkg::*;
#(
  parameter int DSIZE = 24,
  parameter int ASIZE = 32,
  parameter int LSIZE = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [ASIZE-1:0] stride,
  input  logic [LSIZE-1:0] hactive,
  input  logic [LSIZE-1:0] vactive,
  input  logic [LSIZE-1:0] line_words,
  output logic             busy,
  output logic             frame_done,
  output logic             err_len,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  output logic             s_ready,
  output logic             pk_wr_en,
  output logic [DSIZE-1:0] pk_data,
  output logic             pk_align,
  output logic             pk_last,
  input  logic             pk_owr_en,
  input  logic             pk_olast_en,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ASIZE-1:0] cmd_addr,
  output logic [LSIZE-1:0] cmd_words
);

  seq_state_t       state, state_nx;
  logic [LSIZE-1:0] hact_q, vact_q, lwords_q, pix_q, line;
  logic             start_ok, zero_cfg, last_pix, last_line, flush_end;

  // DONE counts as not busy, so a start arriving there is honoured.
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign zero_cfg  = (hactive == '0) || (vactive == '0);
  assign last_pix  = (pix_q == hact_q - LSIZE'(1));
  assign last_line = (line == vact_q - LSIZE'(1));
  assign flush_end = (state == FLUSH_STATE) && pk_olast_en;
  assign cmd_words = lwords_q;

  combin_seq_addr_gen #(.ASIZE(ASIZE), .LSIZE(LSIZE)) u_addr_gen (
    .clock   (clock),
    .rst     (rst),
    .load    (start_ok),
    .base    (base_addr),
    .stride  (stride),
    .advance (flush_end && !last_line),
    .addr    (cmd_addr),
    .line    (line)
  );

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and state-decoded control outputs.
  always_comb begin
    state_nx   = state;
    s_ready    = 1'b0;
    cmd_valid  = 1'b0;
    pk_align   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = zero_cfg ? ST_DONE : ST_ALIGN;
      end
      ST_ALIGN: begin
        pk_align = 1'b1;
        busy     = 1'b1;
        state_nx = ST_CMD;
      end
      ST_CMD: begin
        cmd_valid = 1'b1;
        busy      = 1'b1;
        if (cmd_ready) state_nx = ST_LINE;
      end
      ST_LINE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && last_pix) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (pk_olast_en) state_nx = last_line ? ST_DONE : ST_ALIGN;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        if (start) state_nx = zero_cfg ? ST_DONE : ST_ALIGN;
        else       state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Frame config capture, pixel counter and registered packer write port.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hact_q   <= '0;
      vact_q   <= '0;
      lwords_q <= '0;
      pix_q    <= '0;
      pk_wr_en <= 1'b0;
      pk_data  <= '0;
      pk_last  <= 1'b0;
    end else begin
      pk_wr_en <= 1'b0;
      pk_last  <= 1'b0;
      if (start_ok) begin
        hact_q   <= hactive;
        vact_q   <= vactive;
        lwords_q <= line_words;
      end
      if (state == ALIGN_STATE) begin
        pix_q <= '0;
      end else if (state == ST_LINE && s_valid) begin
        pix_q    <= pix_q + LSIZE'(1);
        pk_wr_en <= 1'b1;
        pk_data  <= s_data;
        pk_last  <= last_pix;
      end
    end
  end

`ifdef COMBIN_SEQ_LEN_CHECK_EN
  logic [LSIZE-1:0] wcnt_q, wcnt_fin;

  // The olast cycle always closes one word: either the strobed full word or
  // the partial tail, so the final count is the running count plus one.
  assign wcnt_fin = wcnt_q + LSIZE'(1);

  // Packed-word counter per line and sticky length-mismatch flag.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      err_len <= 1'b0;
    end else begin
      if (start_ok) err_len <= 1'b0;
      if (state == ALIGN_STATE)  wcnt_q <= LSIZE'(pk_owr_en);
      else if (pk_owr_en)        wcnt_q <= wcnt_q + LSIZE'(1);
      if (flush_end && (wcnt_fin != lwords_q)) err_len <= 1'b1;
    end
  end
`else
  logic unused_owr_en;
  assign unused_owr_en = pk_owr_en;
  assign err_len       = 1'b0;
`endif

endmodule
